// File: rtl/rv64g_reg_lock_tracker.sv
// -----------------------------------------------------------------------------
// rv64g_reg_lock_tracker
//
// Scoreboard for outstanding register writes. Each architectural register has
// a small counter of in-flight writes. Issues increment it and write-backs
// decrement it. A register is "locked" while its counter is non-zero. Issues
// to a register that already has NOS writes in flight are back-pressured.
// x0 is never tracked.
//
// Ports
//   clk_i          clock, all state updates on the rising edge
//   arst_ni        asynchronous active-low reset
//   clear_i        synchronous flush of all counters and locks (err_o kept)
//   issue_rd_i     destination register of the launching instruction
//   issue_valid_i  launcher presents an instruction writing issue_rd_i
//   issue_ready_o  tracker accepts the issue this cycle
//   wb_rd_i        register being written back
//   wb_valid_i     write-back completes this cycle (always accepted)
//   locks_o        registered per-register lock vector (bit 0 always 0)
//   err_o          sticky protocol-error flag
//
// Configuration
//   RV64G_REG_LOCK_ERR_EN  when defined, err_o is set by an underflow
//                          write-back, or by an issue stalled for more than
//                          255 consecutive cycles. When it is not defined,
//                          err_o is tied to 0.
// -----------------------------------------------------------------------------

package rv64g_pkg;
  localparam int NUM_REGS        = 64;
  localparam int NUM_OUTSTANDING = 4;
endpackage

module rv64g_reg_lock_tracker #(
  parameter  int NR  = rv64g_pkg::NUM_REGS,
  parameter  int NOS = rv64g_pkg::NUM_OUTSTANDING,
  localparam int IW  = $clog2(NR),
  localparam int CW  = $clog2(NOS + 1)
) (
  input  logic          clk_i,
  input  logic          arst_ni,
  input  logic          clear_i,
  input  logic [IW-1:0] issue_rd_i,
  input  logic          issue_valid_i,
  output logic          issue_ready_o,
  input  logic [IW-1:0] wb_rd_i,
  input  logic          wb_valid_i,
  output logic [NR-1:0] locks_o,
  output logic          err_o
);

  localparam logic [CW-1:0] NOS_C = CW'(NOS);

  logic [CW-1:0] cnt_q [NR];
  logic [CW-1:0] cnt_d [NR];
  logic [NR-1:0] lock_q;
  logic [NR-1:0] lock_d;
  logic [NR-1:0] iss_hit;
  logic [NR-1:0] wb_hit;
  logic          issue_fire;

  // Ready looks only at registered counters: a same-cycle write-back does not
  // free a slot until the next cycle.
  assign issue_ready_o = (issue_rd_i == '0) || (cnt_q[issue_rd_i] < NOS_C);
  assign issue_fire    = issue_valid_i & issue_ready_o;

  assign iss_hit = (issue_fire && issue_rd_i != '0) ? (NR'(1) << issue_rd_i) : '0;
  assign wb_hit  = (wb_valid_i && wb_rd_i != '0) ? (NR'(1) << wb_rd_i) : '0;

  // An issue and write-back to the same register cancel out. A write-back to
  // an empty counter is ignored (underflow).
  always_comb begin
    for (int r = 0; r < NR; r++) begin
      cnt_d[r] = cnt_q[r];
      if (iss_hit[r] && !wb_hit[r]) begin
        cnt_d[r] = cnt_q[r] + CW'(1);
      end else if (wb_hit[r] && !iss_hit[r] && cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - CW'(1);
      end
      if (clear_i) begin
        cnt_d[r] = '0;
      end
    end
  end

  always_comb begin
    lock_d = '0;
    for (int r = 1; r < NR; r++) begin
      lock_d[r] = (cnt_d[r] != '0);
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      for (int r = 0; r < NR; r++) begin
        cnt_q[r] <= '0;
      end
      lock_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
    end
  end

  assign locks_o = lock_q;

`ifdef RV64G_REG_LOCK_ERR_EN
  logic [7:0] stall_cnt_q;
  logic       err_q;
  logic       stall;
  logic       underflow;

  assign stall     = issue_valid_i & ~issue_ready_o;
  // A write-back paired with a same-register issue is not an underflow; a
  // write-back swallowed by a flush is not checked.
  assign underflow = wb_valid_i && (wb_rd_i != '0) && (cnt_q[wb_rd_i] == '0) &&
                     !(issue_fire && issue_rd_i == wb_rd_i) && !clear_i;

  // stall_cnt_q holds the number of consecutive stalled cycles already seen;
  // reaching 255 on yet another stalled edge means more than 255 cycles.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (stall) begin
        if (stall_cnt_q != 8'hFF) begin
          stall_cnt_q <= stall_cnt_q + 8'd1;
        end
      end else begin
        stall_cnt_q <= '0;
      end
      if (underflow || (stall && stall_cnt_q == 8'hFF)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rv64g_reg_lock_tracker.sv
module tb_rv64g_reg_lock_tracker;

  localparam int NR  = 64;
  localparam int NOS = 4;
`ifdef RV64G_REG_LOCK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk;
  logic          arst_n;
  logic          clear;
  logic [5:0]    issue_rd;
  logic          issue_valid;
  logic          issue_ready;
  logic [5:0]    wb_rd;
  logic          wb_valid;
  logic [NR-1:0] locks;
  logic          err;

  rv64g_reg_lock_tracker #(.NR(NR), .NOS(NOS)) dut (
    .clk_i        (clk),
    .arst_ni      (arst_n),
    .clear_i      (clear),
    .issue_rd_i   (issue_rd),
    .issue_valid_i(issue_valid),
    .issue_ready_o(issue_ready),
    .wb_rd_i      (wb_rd),
    .wb_valid_i   (wb_valid),
    .locks_o      (locks),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    logic          iv;
    logic [5:0]    ird;
    logic          wv;
    logic [5:0]    wrd;
    logic          clr;
    logic          exp_ready;
    logic [63:0]   exp_locks;
    logic          exp_err;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [63:0] b(input int n);
    return 64'(1) << n;
  endfunction

  function automatic vec_t mk(input logic iv, input int ird, input logic wv, input int wrd,
                              input logic clr, input logic rdy, input logic [63:0] lk,
                              input logic e);
    vec_t v;
    v.iv = iv; v.ird = 6'(ird); v.wv = wv; v.wrd = 6'(wrd); v.clr = clr;
    v.exp_ready = rdy; v.exp_locks = lk; v.exp_err = e;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic [5:0] ird, input logic wv,
                       input logic [5:0] wrd, input logic clr);
    issue_valid = iv; issue_rd = ird; wb_valid = wv; wb_rd = wrd; clear = clr;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0);
    @(negedge clk); arst_n = 1'b0;
    @(negedge clk); arst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Reference model: one integer count of in-flight writes per register.
  int m_cnt [NR];
  bit m_err;
  int m_stall;

  task automatic model_reset();
    for (int r = 0; r < NR; r++) m_cnt[r] = 0;
    m_err = 0;
    m_stall = 0;
  endtask

  function automatic logic [63:0] model_locks();
    logic [63:0] v = '0;
    for (int r = 1; r < NR; r++) v[r] = (m_cnt[r] > 0);
    return v;
  endfunction

  initial begin
    arst_n = 1'b0;
    drive(0, 0, 0, 0, 0);
    #12 arst_n = 1'b1;
    @(posedge clk); #1;

    // Reset state
    @(negedge clk);
    chk("reset_locks", locks, 64'h0);
    chk("reset_err", {63'h0, err}, 64'h0);
    chk("reset_ready_x0", {63'h0, issue_ready}, 64'h1);
    issue_rd = 6'd5; #1;
    chk("reset_ready_x5", {63'h0, issue_ready}, 64'h1);
    @(posedge clk); #1;

    // Directed vector table; each row lasts one cycle and the expected
    // outputs are those observed while the row is applied.
    tbl.push_back(mk(1, 5, 0, 0, 0, 1, 64'h0, 0));
    tbl.push_back(mk(0, 5, 1, 5, 0, 1, b(5), 0));
    tbl.push_back(mk(0, 5, 0, 0, 0, 1, 64'h0, 0));
    tbl.push_back(mk(1, 7, 0, 0, 0, 1, 64'h0, 0));
    tbl.push_back(mk(1, 7, 0, 0, 0, 1, b(7), 0));
    tbl.push_back(mk(1, 7, 0, 0, 0, 1, b(7), 0));
    tbl.push_back(mk(1, 7, 0, 0, 0, 1, b(7), 0));
    tbl.push_back(mk(1, 7, 0, 0, 0, 0, b(7), 0));
    tbl.push_back(mk(1, 8, 0, 0, 0, 1, b(7), 0));
    tbl.push_back(mk(1, 7, 1, 7, 0, 0, b(7) | b(8), 0));
    tbl.push_back(mk(0, 7, 0, 0, 0, 1, b(7) | b(8), 0));
    tbl.push_back(mk(1, 3, 1, 8, 0, 1, b(7) | b(8), 0));
    tbl.push_back(mk(1, 3, 1, 3, 0, 1, b(7) | b(3), 0));
    tbl.push_back(mk(0, 3, 0, 0, 0, 1, b(7) | b(3), 0));
    tbl.push_back(mk(1, 4, 0, 0, 1, 1, b(7) | b(3), 0));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(1, 0, 1, 0, 0, 1, 64'h0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 64'h0, 0));
    tbl.push_back(mk(1, 2, 0, 0, 0, 1, 64'h0, 0));
    tbl.push_back(mk(1, 9, 0, 0, 0, 1, b(2), 0));
    tbl.push_back(mk(1, 4, 0, 0, 1, 1, b(2) | b(9), 0));
    tbl.push_back(mk(0, 4, 0, 0, 0, 1, 64'h0, 0));
    tbl.push_back(mk(0, 6, 1, 6, 0, 1, 64'h0, 0));
    tbl.push_back(mk(0, 6, 0, 0, 0, 1, 64'h0, ERR_EN));
    tbl.push_back(mk(0, 6, 0, 0, 1, 1, 64'h0, ERR_EN));
    tbl.push_back(mk(0, 6, 0, 0, 0, 1, 64'h0, ERR_EN));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].iv, tbl[i].ird, tbl[i].wv, tbl[i].wrd, tbl[i].clr);
      @(negedge clk);
      chk($sformatf("tbl%0d_ready", i), {63'h0, issue_ready}, {63'h0, tbl[i].exp_ready});
      chk($sformatf("tbl%0d_locks", i), locks, tbl[i].exp_locks);
      chk($sformatf("tbl%0d_err", i), {63'h0, err}, {63'h0, tbl[i].exp_err});
      @(posedge clk); #1;
    end

    // Reset in the middle of operation, then a stale write-back.
    drive(1, 10, 0, 0, 0);
    @(posedge clk); #1;
    drive(0, 10, 0, 0, 0);
    #1;
    chk("midrst_locked", locks, b(10));
    #2 arst_n = 1'b0;
    #1;
    chk("midrst_async_locks", locks, 64'h0);
    chk("midrst_async_err", {63'h0, err}, 64'h0);
    chk("midrst_ready", {63'h0, issue_ready}, 64'h1);
    @(negedge clk); arst_n = 1'b1;
    @(posedge clk); #1;
    drive(0, 10, 1, 10, 0);
    @(negedge clk);
    chk("stale_wb_locks", locks, 64'h0);
    @(posedge clk); #1;
    drive(0, 10, 0, 0, 0);
    @(negedge clk);
    chk("stale_wb_locks_after", locks, 64'h0);
    chk("stale_wb_err", {63'h0, err}, {63'h0, ERR_EN});

`ifdef RV64G_REG_LOCK_ERR_EN
    // Stall timeout: four accepted issues fill rd=7, then the request is held.
    do_reset();
    drive(1, 7, 0, 0, 0);
    repeat (4) begin @(posedge clk); #1; end
    repeat (255) begin @(posedge clk); #1; end
    chk("stall255_err", {63'h0, err}, 64'h0);
    @(posedge clk); #1;
    chk("stall256_err", {63'h0, err}, 64'h1);
`endif

    // Randomized run against the reference model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic iv, wv, clr, exp_ready, fire, under, stall;
      logic [5:0] ird, wrd;
      iv  = ($urandom_range(0, 9) < 6);
      wv  = ($urandom_range(0, 9) < 5);
      clr = ($urandom_range(0, 99) == 0);
      ird = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
      wrd = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 7));
      if (clr) wv = 1'b0;
      drive(iv, ird, wv, wrd, clr);
      @(negedge clk);
      exp_ready = (ird == 0) || (m_cnt[ird] < NOS);
      chk("rnd_ready", {63'h0, issue_ready}, {63'h0, exp_ready});
      chk("rnd_locks", locks, model_locks());
      chk("rnd_err", {63'h0, err}, {63'h0, m_err});

      fire  = iv && exp_ready;
      stall = iv && !exp_ready;
      under = 1'b0;
      if (clr) begin
        for (int r = 0; r < NR; r++) m_cnt[r] = 0;
      end else if (fire && wv && ird == wrd) begin
        // paired issue and write-back on one register: no net change
      end else begin
        if (fire && ird != 0) m_cnt[ird]++;
        if (wv && wrd != 0) begin
          if (m_cnt[wrd] > 0) m_cnt[wrd]--;
          else under = 1'b1;
        end
      end
      m_stall = stall ? m_stall + 1 : 0;
      if (ERR_EN && (under || m_stall > 255)) m_err = 1'b1;
      @(posedge clk); #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
